parking_gate_arbiter: RTL and testbench

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_pkg.sv | 19 +
 rtl/parking_lane_fsm.sv | 74 +++++++
 rtl/parking_gate_arbiter.sv | 128 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: lane state encoding, default sizing and a small helper shared by the
// parking gate arbiter and its lane FSMs.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } lane_state_e;

  localparam int unsigned DEF_CAPACITY     = 15;
  localparam int unsigned DEF_GATE_TIMEOUT = 8;

  // Number of set bits in a two-lane vector.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: one entry-lane barrier controller (IDLE/OPEN/CLOSE) with open-time timer.
// Reports whether the lane can take a grant, and when its reservation is given back.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic in_pulse,
  output logic gate_open,
  output logic idle,
  output logic rel_res,
  output logic tailgate
);

  localparam int unsigned TMR_W = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_TIMEOUT - 1);

  lane_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_open_q, gate_open_d;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = OPEN;
          timer_d = TMR_LOAD;
        end
      end
      OPEN: begin
        // A car arriving on the expiry cycle still counts as a proper entry.
        if (in_pulse || (timer_q == '0)) begin
          state_d = CLOSE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    gate_open_d = (state_d == OPEN);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open_q <= gate_open_d;
    end
  end

  assign gate_open = gate_open_q;
  assign idle      = (state_q == IDLE);
  assign rel_res   = (state_q == OPEN) && (in_pulse || (timer_q == '0));
  assign tailgate  = in_pulse && (state_q != OPEN);

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: grants two entry lanes against free spaces and tracks occupancy
// and reservations. Define PARKING_ALARM_EN to build the sticky fault alarm.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter  int unsigned CAPACITY     = DEF_CAPACITY,
  parameter  int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  localparam int unsigned CNT_W        = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       in_pulse,
  input  logic             out_pulse,
  input  logic             sens_err,
  output logic [1:0]       gate_open,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             alarm
);

  // Two guard bits keep the intermediate sums and differences from wrapping.
  localparam int unsigned  W     = CNT_W + 2;
  localparam logic [W-1:0] CAP_W = W'(CAPACITY);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reserved_q, reserved_d;
  logic             rr_q, rr_d;

  logic [1:0]   lane_idle, rel_res, tailgate, elig, grant;
  logic [W-1:0] occ_res, free, res_sum, cnt_sum, cnt_limit;
  logic         underflow;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    parking_lane_fsm #(
      .GATE_TIMEOUT(GATE_TIMEOUT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .grant    (grant[i]),
      .in_pulse (in_pulse[i]),
      .gate_open(gate_open[i]),
      .idle     (lane_idle[i]),
      .rel_res  (rel_res[i]),
      .tailgate (tailgate[i])
    );
  end

  assign occ_res = {2'b00, count_q} + {2'b00, reserved_q};
  assign free    = CAP_W - occ_res;
  assign elig    = req & lane_idle;

  always_comb begin
    grant = 2'b00;
    rr_d  = rr_q;
    if (free >= W'(2)) begin
      grant = elig;
    end else if (free == W'(1)) begin
      // Only a contested last space consults and advances the pointer.
      if (elig == 2'b11) begin
        grant = rr_q ? 2'b10 : 2'b01;
        rr_d  = ~rr_q;
      end else begin
        grant = elig;
      end
    end
  end

  always_comb begin
    res_sum   = {2'b00, reserved_q} + W'(popcount2(grant)) - W'(popcount2(rel_res));
    cnt_sum   = {2'b00, count_q} + W'(popcount2(in_pulse));
    underflow = 1'b0;
    if (out_pulse) begin
      if (cnt_sum == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_sum = cnt_sum - W'(1);
      end
    end
    // Entries through an open gate never reach this limit; only tailgaters are clipped.
    cnt_limit = CAP_W - res_sum;
    if (cnt_sum > cnt_limit) begin
      cnt_sum = cnt_limit;
    end
    reserved_d = res_sum[CNT_W-1:0];
    count_d    = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      reserved_q <= '0;
      rr_q       <= 1'b0;
    end else begin
      count_q    <= count_d;
      reserved_q <= reserved_d;
      rr_q       <= rr_d;
    end
  end

  assign count = count_q;
  assign full  = (occ_res == CAP_W);
  assign empty = (count_q == '0);

`ifdef PARKING_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q | underflow | (|tailgate) | sens_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_fault;
  assign unused_fault = ^{underflow, tailgate, sens_err};
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed tables, hand sequences and random stimulus checked
// against a lane/occupancy reference model for a default and a two-space instance.
module tb_parking_gate_arbiter;

  localparam int CAP_A = 15;
  localparam int TO_A  = 8;
  localparam int CAP_B = 2;
  localparam int TO_B  = 3;
  localparam int CW_A  = $clog2(CAP_A + 1);
  localparam int CW_B  = $clog2(CAP_B + 1);

`ifdef PARKING_ALARM_EN
  localparam logic ALARM_BUILD = 1'b1;
`else
  localparam logic ALARM_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0][1:0] req_v;
  logic [1:0][1:0] in_v;
  logic [1:0]      out_v;
  logic [1:0]      err_v;
  logic [1:0][1:0] go_v;
  logic [1:0]      full_v, empty_v, alarm_v;
  logic [CW_A-1:0] count_a;
  logic [CW_B-1:0] count_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter #(.CAPACITY(CAP_A), .GATE_TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .req(req_v[0]), .in_pulse(in_v[0]), .out_pulse(out_v[0]),
    .sens_err(err_v[0]), .gate_open(go_v[0]), .count(count_a), .full(full_v[0]),
    .empty(empty_v[0]), .alarm(alarm_v[0])
  );

  parking_gate_arbiter #(.CAPACITY(CAP_B), .GATE_TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .req(req_v[1]), .in_pulse(in_v[1]), .out_pulse(out_v[1]),
    .sens_err(err_v[1]), .gate_open(go_v[1]), .count(count_b), .full(full_v[1]),
    .empty(empty_v[1]), .alarm(alarm_v[1])
  );

  // Reference model: each lane is "cycles it will still be open" plus a one-cycle cool-down.
  int m_cap [2] = '{CAP_A, CAP_B};
  int m_to  [2] = '{TO_A, TO_B};
  int m_open[2][2];
  bit m_cool[2][2];
  int m_occ [2];
  int m_res [2];
  int m_ptr [2];
  bit m_alarm[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_open[k][i] = 0;
        m_cool[k][i] = 1'b0;
      end
      m_occ[k]   = 0;
      m_res[k]   = 0;
      m_ptr[k]   = 0;
      m_alarm[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int free, nin, occ_new, limit;
    bit [1:0] elig, g;
    bit tg, uf;
    free = m_cap[k] - m_occ[k] - m_res[k];
    for (int i = 0; i < 2; i++)
      elig[i] = req_v[k][i] && (m_open[k][i] == 0) && !m_cool[k][i];
    g = 2'b00;
    if (free >= 2) g = elig;
    else if (free == 1) begin
      if (elig == 2'b11) begin
        g[m_ptr[k]] = 1'b1;
        m_ptr[k] = 1 - m_ptr[k];
      end else g = elig;
    end
    nin = 0;
    tg  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (in_v[k][i]) begin
        nin++;
        if (m_open[k][i] == 0) tg = 1'b1;
      end
      if (m_open[k][i] > 0) begin
        if (in_v[k][i] || m_open[k][i] == 1) begin
          m_open[k][i] = 0;
          m_cool[k][i] = 1'b1;
          m_res[k]--;
        end else m_open[k][i]--;
      end else if (m_cool[k][i]) m_cool[k][i] = 1'b0;
      else if (g[i]) begin
        m_open[k][i] = m_to[k];
        m_res[k]++;
      end
    end
    occ_new = m_occ[k] + nin - int'(out_v[k]);
    uf = (occ_new < 0);
    if (uf) occ_new = 0;
    limit = m_cap[k] - m_res[k];
    if (occ_new > limit) occ_new = limit;
    m_occ[k] = occ_new;
    if (ALARM_BUILD && (uf || tg || err_v[k])) m_alarm[k] = 1'b1;
  endtask

  task automatic compare_model(input int k);
    int cnt;
    logic [1:0] exp_go;
    cnt = (k == 0) ? int'(count_a) : int'(count_b);
    exp_go = {m_open[k][1] > 0, m_open[k][0] > 0};
    check($sformatf("model%0d.gate_open", k), 32'(go_v[k]), 32'(exp_go));
    check($sformatf("model%0d.count", k), cnt, m_occ[k]);
    check($sformatf("model%0d.full", k), 32'(full_v[k]), 32'(m_occ[k] + m_res[k] == m_cap[k]));
    check($sformatf("model%0d.empty", k), 32'(empty_v[k]), 32'(m_occ[k] == 0));
    check($sformatf("model%0d.alarm", k), 32'(alarm_v[k]), 32'(m_alarm[k]));
  endtask

  task automatic clear_inputs();
    req_v = '0;
    in_v  = '0;
    out_v = '0;
    err_v = '0;
  endtask

  // Apply the currently driven inputs across one rising edge, then check both instances.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    compare_model(0);
    compare_model(1);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d.gate_open", k), 32'(go_v[k]), 0);
      check($sformatf("reset%0d.full", k), 32'(full_v[k]), 0);
      check($sformatf("reset%0d.empty", k), 32'(empty_v[k]), 1);
      check($sformatf("reset%0d.alarm", k), 32'(alarm_v[k]), 0);
    end
    check("reset0.count", 32'(count_a), 0);
    check("reset1.count", 32'(count_b), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One lane-0 entry on instance k: grant, car enters, gate finishes closing.
  task automatic enter_lane0(input int k);
    req_v[k] = 2'b01;
    cycle();
    req_v[k] = 2'b00;
    in_v[k]  = 2'b01;
    cycle();
    in_v[k]  = 2'b00;
    cycle();
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] inp;
    logic [1:0] go;
    int         cnt;
    logic       empty;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Instance A, from reset: entry after 3 open cycles, then an 8-cycle timeout.
    tbl[0]  = '{2'b01, 2'b00, 2'b01, 0, 1'b1};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 0, 1'b1};
    tbl[2]  = '{2'b00, 2'b00, 2'b01, 0, 1'b1};
    tbl[3]  = '{2'b00, 2'b01, 2'b00, 1, 1'b0};
    tbl[4]  = '{2'b00, 2'b00, 2'b00, 1, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 2'b01, 1, 1'b0};
    for (int i = 6; i <= 12; i++) tbl[i] = '{2'b00, 2'b00, 2'b01, 1, 1'b0};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 1, 1'b0};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 1, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      req_v[0] = tbl[i].req;
      in_v[0]  = tbl[i].inp;
      cycle();
      check($sformatf("tbl[%0d].gate_open", i), 32'(go_v[0]), 32'(tbl[i].go));
      check($sformatf("tbl[%0d].count", i), 32'(count_a), tbl[i].cnt);
      check($sformatf("tbl[%0d].empty", i), 32'(empty_v[0]), 32'(tbl[i].empty));
    end
    check("timeout.full_clear", 32'(full_v[0]), 0);

    // Count to 5, then entry and exit on the same edge.
    for (int n = 0; n < 4; n++) enter_lane0(0);
    check("fill5.count", 32'(count_a), 5);
    req_v[0] = 2'b01;
    cycle();
    check("net.gate_opened", 32'(go_v[0]), 1);
    req_v[0] = 2'b00;
    in_v[0]  = 2'b01;
    out_v[0] = 1'b1;
    cycle();
    in_v[0]  = 2'b00;
    out_v[0] = 1'b0;
    check("net.count", 32'(count_a), 5);
    check("net.gate_closed", 32'(go_v[0]), 0);
    cycle();

    // Asynchronous reset while the gate is open.
    req_v[0] = 2'b01;
    cycle();
    check("rst_mid.gate_before", 32'(go_v[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.gate_now", 32'(go_v[0]), 0);
    check("rst_mid.empty", 32'(empty_v[0]), 1);
    do_reset();

    // Exit with an empty lot.
    out_v[0] = 1'b1;
    cycle();
    out_v[0] = 1'b0;
    check("underflow.count", 32'(count_a), 0);
    check("underflow.alarm", 32'(alarm_v[0]), 32'(ALARM_BUILD));
    do_reset();

    // Instance B (2 spaces, 3-cycle timeout): contested last space.
    enter_lane0(1);
    check("rr.count1", 32'(count_b), 1);
    req_v[1] = 2'b11;
    cycle();
    check("rr.first_lane0", 32'(go_v[1]), 2'b01);
    req_v[1] = 2'b00;
    cycle();
    check("rr.lane1_closed_a", 32'(go_v[1]), 2'b01);
    cycle();
    check("rr.lane1_closed_b", 32'(go_v[1]), 2'b01);
    cycle();
    check("rr.lane0_timeout", 32'(go_v[1]), 2'b00);
    cycle();
    req_v[1] = 2'b11;
    cycle();
    check("rr.second_lane1", 32'(go_v[1]), 2'b10);
    req_v[1] = 2'b00;
    for (int n = 0; n < 2; n++) begin
      cycle();
      check($sformatf("rr.lane0_closed_%0d", n), 32'(go_v[1]), 2'b10);
    end
    cycle();
    check("rr.lane1_timeout", 32'(go_v[1]), 2'b00);
    cycle();

    // Full lot: no grants until a car leaves, then a grant on the next edge.
    enter_lane0(1);
    check("full.count", 32'(count_b), 2);
    check("full.flag", 32'(full_v[1]), 1);
    req_v[1] = 2'b11;
    cycle();
    check("full.no_grant_a", 32'(go_v[1]), 2'b00);
    cycle();
    check("full.no_grant_b", 32'(go_v[1]), 2'b00);
    out_v[1] = 1'b1;
    cycle();
    out_v[1] = 1'b0;
    check("full.exit_count", 32'(count_b), 1);
    check("full.exit_flag", 32'(full_v[1]), 0);
    check("full.exit_no_gate_yet", 32'(go_v[1]), 2'b00);
    cycle();
    check("full.next_grant", 32'(go_v[1]), 2'b01);
    do_reset();

    // Random traffic on both instances against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        req_v[k] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++)
          in_v[k][i] = go_v[k][i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
        out_v[k] = ($urandom_range(0, 5) == 0);
        err_v[k] = ($urandom_range(0, 299) == 0);
      end
      if (c == 700) begin
        do_reset();
      end else begin
        cycle();
      end
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
